// File: rtl/tetris_pkg.sv
// Shared constants and types for the title banner: geometry, colour type and
// the constant divide-by-3 used to undo the 3x pixel replication.
package tetris_pkg;

  localparam int TITLE_LETTERS = 6;
  localparam int LETTER_W      = 10;
  localparam int TITLE_ROWS    = 10;
  localparam int TITLE_W       = 180;
  localparam int TITLE_H       = 30;
  localparam int SCALE         = 3;

  typedef logic [11:0] rgb444_t;

  // floor(x/3) as (x*171)>>9 built from shifts; exact for x < 512, which covers the banner box
  function automatic logic [5:0] div3(input logic [9:0] x);
    logic [19:0] p;
    p = ({10'd0, x} << 7) + ({10'd0, x} << 5) + ({10'd0, x} << 3)
      + ({10'd0, x} << 1) + {10'd0, x};
    return 6'(p >> 9);
  endfunction

endpackage

// File: rtl/tetris_title_if.sv
// Address/data bus between the banner renderer and its font and colour ROMs.
interface tetris_title_if;
  import tetris_pkg::*;

  logic [3:0]  font_addr;
  logic [59:0] font_data;
  logic [2:0]  color_addr;
  rgb444_t     color;

  modport master (output font_addr, output color_addr, input font_data, input color);
  modport slave  (input font_addr, input color_addr, output font_data, output color);
endinterface

// File: rtl/tetris_title_anim.sv
// Colour-rotation timer: counts frame_start pulses and advances the letter
// colour offset through 0..5 every FRAMES_PER_STEP frames.
module tetris_title_anim #(
  parameter int FRAMES_PER_STEP = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       anim_en,
  output logic [2:0] color_ofs
);

  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  logic [CW-1:0] frame_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_cnt <= '0;
      color_ofs <= '0;
    end else if (frame_start && anim_en) begin
      if (frame_cnt == CW'(FRAMES_PER_STEP - 1)) begin
        frame_cnt <= '0;
        color_ofs <= (color_ofs == 3'd5) ? 3'd0 : color_ofs + 3'd1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tetris_title_renderer.sv
// Two-stage banner pipeline: stage 0 maps scan position to ROM addresses,
// stage 1 picks the font bit and registers the pixel colour.
module tetris_title_renderer
  import tetris_pkg::*;
#(
  parameter int X0              = 400,
  parameter int Y0              = 40,
  parameter int FRAMES_PER_STEP = 15
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [9:0]     DrawX,
  input  logic [9:0]     DrawY,
  input  logic           vde,
  input  logic           frame_start,
  input  logic           anim_en,
  tetris_title_if.master rom,
  output logic           title_on,
  output logic [3:0]     red,
  output logic [3:0]     green,
  output logic [3:0]     blue
);

  logic [2:0] color_ofs;
  logic       in_box;
  logic [9:0] relx, rely;
  logic [5:0] col;
  logic [3:0] row;
  logic [2:0] letter;
  logic [3:0] sum;
  logic [2:0] cidx;
  logic [5:0] col_q;
  logic       s0_valid;

  tetris_title_anim #(.FRAMES_PER_STEP(FRAMES_PER_STEP)) u_anim (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .anim_en     (anim_en),
    .color_ofs   (color_ofs)
  );

  // Compare against both edges directly so DrawX < X0 never relies on wraparound
  assign in_box = vde
               && (DrawX >= 10'(X0)) && (DrawX < 10'(X0 + TITLE_W))
               && (DrawY >= 10'(Y0)) && (DrawY < 10'(Y0 + TITLE_H));

  assign relx = DrawX - 10'(X0);
  assign rely = DrawY - 10'(Y0);
  assign col  = div3(relx);
  assign row  = 4'(div3(rely));

  always_comb begin
    letter = 3'd0;
    if      (col >= 6'd50) letter = 3'd5;
    else if (col >= 6'd40) letter = 3'd4;
    else if (col >= 6'd30) letter = 3'd3;
    else if (col >= 6'd20) letter = 3'd2;
    else if (col >= 6'd10) letter = 3'd1;
  end

  assign sum  = {1'b0, letter} + {1'b0, color_ofs};
  assign cidx = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom.font_addr  <= '0;
      rom.color_addr <= '0;
      col_q          <= '0;
      s0_valid       <= 1'b0;
    end else begin
      s0_valid <= in_box;
      if (in_box) begin
        rom.font_addr  <= row;
        rom.color_addr <= cidx;
        col_q          <= col;
      end
    end
  end

  logic lit;
  assign lit = s0_valid && rom.font_data[6'd59 - col_q];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      title_on <= 1'b0;
      red      <= '0;
      green    <= '0;
      blue     <= '0;
    end else begin
      title_on            <= lit;
      {red, green, blue}  <= lit ? rom.color : 12'h000;
    end
  end

endmodule

// File: tb/tb_tetris_title_renderer.sv
// Directed bench for the title banner with small font/colour ROM models.
module tb_tetris_title_renderer;
  import tetris_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] DrawX, DrawY;
  logic       vde, frame_start, anim_en;
  logic       title_on;
  logic [3:0] red, green, blue;

  int checks   = 0;
  int failures = 0;

  tetris_title_if rom_if ();

  tetris_title_renderer #(.X0(400), .Y0(40), .FRAMES_PER_STEP(2)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .vde         (vde),
    .frame_start (frame_start),
    .anim_en     (anim_en),
    .rom         (rom_if.master),
    .title_on    (title_on),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  always #5 Clk = ~Clk;

  // Font: letters T E T R I S, 10 bits each, bit 9 of each letter = leftmost
  always_comb begin
    rom_if.font_data = '0;
    if (rom_if.font_addr == 4'd0)
      rom_if.font_data = {10'b1111111111, 10'b0111111111, 10'b1111111111,
                          10'b1111111110, 10'b1111111111, 10'b0111111111};
    else if (rom_if.font_addr < 4'd10)
      rom_if.font_data = {10'b0000110000, 10'b0100000000, 10'b0000110000,
                          10'b0100000001, 10'b0000110000, 10'b0111111110};
  end

  always_comb begin
    case (rom_if.color_addr)
      3'd0:    rom_if.color = 12'hf00;
      3'd1:    rom_if.color = 12'hf70;
      3'd2:    rom_if.color = 12'hff0;
      3'd3:    rom_if.color = 12'h0f0;
      3'd4:    rom_if.color = 12'h00f;
      3'd5:    rom_if.color = 12'he5f;
      default: rom_if.color = 12'h000;
    endcase
  end

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed on/rgb=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic px(input string tag, input int x, input int y, input logic v,
                    input logic [12:0] exp);
    @(negedge Clk);
    DrawX = 10'(x); DrawY = 10'(y); vde = v;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check(tag, {title_on, red, green, blue}, exp);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk); frame_start = 1'b1;
      @(negedge Clk); frame_start = 1'b0;
    end
  endtask

  logic [12:0] stream_exp [8];

  initial begin
    Reset = 1'b1; DrawX = '0; DrawY = '0; vde = 1'b0;
    frame_start = 1'b0; anim_en = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_held", {title_on, red, green, blue}, 13'h0000);
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;
    check("after_release", {title_on, red, green, blue}, 13'h0000);

    px("t_origin",     400, 40, 1'b1, {1'b1, 12'hf00});
    px("e_col0_unlit", 430, 40, 1'b1, {1'b0, 12'h000});
    px("e_col1_lit",   433, 40, 1'b1, {1'b1, 12'hf70});
    px("last_col",     579, 40, 1'b1, {1'b1, 12'he5f});
    px("x_past_end",   580, 40, 1'b1, {1'b0, 12'h000});
    px("y_past_end",   400, 70, 1'b1, {1'b0, 12'h000});
    px("vde_low",      400, 40, 1'b0, {1'b0, 12'h000});
    px("x_before",     399, 40, 1'b1, {1'b0, 12'h000});
    px("row1_col4",    412, 43, 1'b1, {1'b1, 12'hf00});
    px("row1_col3",    409, 43, 1'b1, {1'b0, 12'h000});

    // DrawX 426..433 on row 0 -> cols 8,9,9,9,10,10,10,11
    stream_exp = '{ {1'b1,12'hf00}, {1'b1,12'hf00}, {1'b1,12'hf00}, {1'b1,12'hf00},
                    {1'b0,12'h000}, {1'b0,12'h000}, {1'b0,12'h000}, {1'b1,12'hf70} };
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (i < 8) begin
        DrawX = 10'(426 + i); DrawY = 10'd40; vde = 1'b1;
      end else begin
        vde = 1'b0;
      end
      @(posedge Clk); #1;
      if (i >= 1 && i <= 8)
        check($sformatf("stream_%0d", i - 1), {title_on, red, green, blue}, stream_exp[i - 1]);
    end

    vde = 1'b0; anim_en = 1'b1;
    pulses(2);
    px("anim_step1",   400, 40, 1'b1, {1'b1, 12'hf70});
    px("anim_letter5", 579, 40, 1'b1, {1'b1, 12'hf00});
    vde = 1'b0;
    pulses(10);
    px("anim_wrap",    400, 40, 1'b1, {1'b1, 12'hf00});

    vde = 1'b0;
    pulses(1);
    anim_en = 1'b0;
    pulses(3);
    px("anim_frozen",  400, 40, 1'b1, {1'b1, 12'hf00});
    vde = 1'b0; anim_en = 1'b1;
    pulses(1);
    px("anim_resume",  400, 40, 1'b1, {1'b1, 12'hf70});

    #2 Reset = 1'b1;
    #1;
    check("async_reset", {title_on, red, green, blue}, 13'h0000);
    @(negedge Clk); Reset = 1'b0;
    px("post_reset_base", 400, 40, 1'b1, {1'b1, 12'hf00});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
